// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between the pipeline writeback stage and a vector loader.
// Optional ARB_STATS_EN adds saturating grant/drop counters.
module rf_wb_arbiter #(
    parameter int LANES      = 3,
    parameter int DW         = 18,
    parameter int AW         = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pipe_we,
    input  logic [AW-1:0]       pipe_wa,
    input  logic [LANES*DW-1:0] pipe_wd,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [AW-1:0]       ld_wa,
    input  logic [LANES*DW-1:0] ld_wd,
    output logic                ld_drop,
    output logic                pipe_stall,
`ifdef ARB_STATS_EN
    output logic [15:0]         stat_pipe,
    output logic [15:0]         stat_ld,
    output logic [15:0]         stat_drop,
`endif
    output logic                rf_we,
    output logic [AW-1:0]       rf_wa,
    output logic [LANES*DW-1:0] rf_wd
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         hold_wa_q, hold_wa_d;
    logic [LANES*DW-1:0]   hold_wd_q, hold_wd_d;
    logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
    logic                  rf_we_q, rf_we_d;
    logic [AW-1:0]         rf_wa_q, rf_wa_d;
    logic [LANES*DW-1:0]   rf_wd_q, rf_wd_d;
    logic                  ld_ready_q, ld_ready_d;
    logic                  ld_drop_q, ld_drop_d;
    logic                  pipe_stall_q, pipe_stall_d;
    logic                  grant_ld;

    always_comb begin
        state_d    = state_q;
        hold_wa_d  = hold_wa_q;
        hold_wd_d  = hold_wd_q;
        wait_cnt_d = wait_cnt_q;
        rf_we_d    = 1'b0;
        rf_wa_d    = rf_wa_q;
        rf_wd_d    = rf_wd_q;
        ld_drop_d  = 1'b0;
        grant_ld   = 1'b0;

        // The pipeline always owns the port when it writes.
        if (pipe_we) begin
            rf_we_d = 1'b1;
            rf_wa_d = pipe_wa;
            rf_wd_d = pipe_wd;
        end

        case (state_q)
            IDLE: begin
                if (ld_valid && ld_ready_q) begin
                    if (!pipe_we) begin
                        rf_we_d  = 1'b1;
                        rf_wa_d  = ld_wa;
                        rf_wd_d  = ld_wd;
                        grant_ld = 1'b1;
                    end else if (ld_wa == pipe_wa) begin
                        ld_drop_d = 1'b1;
                    end else begin
                        hold_wa_d  = ld_wa;
                        hold_wd_d  = ld_wd;
                        wait_cnt_d = '0;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT, FORCE: begin
                if (!pipe_we) begin
                    rf_we_d    = 1'b1;
                    rf_wa_d    = hold_wa_q;
                    rf_wd_d    = hold_wd_q;
                    grant_ld   = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = IDLE;
                end else if (pipe_wa == hold_wa_q) begin
                    ld_drop_d  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = IDLE;
                end else if (state_q == WAIT) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_d == STARVE_LIM) begin
                        state_d = FORCE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ld_ready_d   = (state_d == IDLE);
        pipe_stall_d = (state_d == FORCE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_wa_q    <= '0;
            hold_wd_q    <= '0;
            wait_cnt_q   <= '0;
            rf_we_q      <= 1'b0;
            rf_wa_q      <= '0;
            rf_wd_q      <= '0;
            ld_ready_q   <= 1'b0;
            ld_drop_q    <= 1'b0;
            pipe_stall_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_wa_q    <= hold_wa_d;
            hold_wd_q    <= hold_wd_d;
            wait_cnt_q   <= wait_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_wa_q      <= rf_wa_d;
            rf_wd_q      <= rf_wd_d;
            ld_ready_q   <= ld_ready_d;
            ld_drop_q    <= ld_drop_d;
            pipe_stall_q <= pipe_stall_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_wa      = rf_wa_q;
    assign rf_wd      = rf_wd_q;
    assign ld_ready   = ld_ready_q;
    assign ld_drop    = ld_drop_q;
    assign pipe_stall = pipe_stall_q;

`ifdef ARB_STATS_EN
    logic [15:0] stat_pipe_q, stat_pipe_d;
    logic [15:0] stat_ld_q, stat_ld_d;
    logic [15:0] stat_drop_q, stat_drop_d;

    always_comb begin
        stat_pipe_d = stat_pipe_q;
        stat_ld_d   = stat_ld_q;
        stat_drop_d = stat_drop_q;
        if (pipe_we && stat_pipe_q != 16'hFFFF)  stat_pipe_d = stat_pipe_q + 16'd1;
        if (grant_ld && stat_ld_q != 16'hFFFF)   stat_ld_d   = stat_ld_q + 16'd1;
        if (ld_drop_d && stat_drop_q != 16'hFFFF) stat_drop_d = stat_drop_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pipe_q <= '0;
            stat_ld_q   <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_pipe_q <= stat_pipe_d;
            stat_ld_q   <= stat_ld_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_pipe = stat_pipe_q;
    assign stat_ld   = stat_ld_q;
    assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (default build, STARVE_MAX=8).
module tb_rf_wb_arbiter;

    localparam int LANES = 3;
    localparam int DW    = 18;
    localparam int AW    = 4;
    localparam int WD    = LANES * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          pipe_we;
    logic [AW-1:0] pipe_wa;
    logic [WD-1:0] pipe_wd;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_wa;
    logic [WD-1:0] ld_wd;
    logic          ld_drop;
    logic          pipe_stall;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [WD-1:0] rf_wd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.LANES(LANES), .DW(DW), .AW(AW), .STARVE_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wa(ld_wa), .ld_wd(ld_wd),
        .ld_drop(ld_drop), .pipe_stall(pipe_stall),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [WD-1:0] L3 = {18'h20000, 18'h3FFFF, 18'h2AAAA};
    localparam logic [WD-1:0] L6 = {18'h00001, 18'h12345, 18'h0F0F0};
    localparam logic [WD-1:0] P1 = {18'h11111, 18'h22222, 18'h33333};
    localparam logic [WD-1:0] L2 = {18'h04444, 18'h05555, 18'h06666};
    localparam logic [WD-1:0] P7 = {18'h07777, 18'h07777, 18'h07777};
    localparam logic [WD-1:0] L5 = {18'h15555, 18'h25555, 18'h35555};
    localparam logic [WD-1:0] L4 = {18'h01234, 18'h04321, 18'h0ABCD};
    localparam logic [WD-1:0] P4 = {18'h3C3C3, 18'h1E1E1, 18'h0F0F0};
    localparam logic [WD-1:0] P9 = {18'h09999, 18'h09999, 18'h09999};

    initial begin
        rst = 1'b1; pipe_we = 1'b0; pipe_wa = '0; pipe_wd = '0;
        ld_valid = 1'b0; ld_wa = '0; ld_wd = '0;

        // Reset
        tick(); tick();
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_wa", 64'(rf_wa), 64'd0);
        chk("rst_rf_wd", 64'(rf_wd), 64'd0);
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        chk("rst_ld_drop", 64'(ld_drop), 64'd0);
        chk("rst_stall", 64'(pipe_stall), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ld_ready", 64'(ld_ready), 64'd1);
        chk("post_rst_rf_we", 64'(rf_we), 64'd0);

        // Loader alone, back to back
        ld_valid = 1'b1; ld_wa = 4'd3; ld_wd = L3;
        tick();
        chk("ld_we", 64'(rf_we), 64'd1);
        chk("ld_wa", 64'(rf_wa), 64'd3);
        chk("ld_wd", 64'(rf_wd), 64'(L3));
        chk("ld_ready_stays", 64'(ld_ready), 64'd1);
        ld_wa = 4'd6; ld_wd = L6;
        tick();
        chk("b2b_we", 64'(rf_we), 64'd1);
        chk("b2b_wa", 64'(rf_wa), 64'd6);
        chk("b2b_wd", 64'(rf_wd), 64'(L6));
        ld_valid = 1'b0;
        tick();
        chk("idle_we", 64'(rf_we), 64'd0);
        chk("idle_wa_hold", 64'(rf_wa), 64'd6);

        // Collision, different addresses
        pipe_we = 1'b1; pipe_wa = 4'd1; pipe_wd = P1;
        ld_valid = 1'b1; ld_wa = 4'd2; ld_wd = L2;
        tick();
        pipe_we = 1'b0; ld_valid = 1'b0;
        chk("col1_we", 64'(rf_we), 64'd1);
        chk("col1_wa", 64'(rf_wa), 64'd1);
        chk("col1_wd", 64'(rf_wd), 64'(P1));
        chk("col1_ready", 64'(ld_ready), 64'd0);
        tick();
        chk("col2_we", 64'(rf_we), 64'd1);
        chk("col2_wa", 64'(rf_wa), 64'd2);
        chk("col2_wd", 64'(rf_wd), 64'(L2));
        chk("col2_ready", 64'(ld_ready), 64'd1);
        tick();
        chk("col3_we", 64'(rf_we), 64'd0);

        // Starvation: capture, then 8 blocked cycles before stall
        pipe_we = 1'b1; pipe_wa = 4'd7; pipe_wd = P7;
        ld_valid = 1'b1; ld_wa = 4'd5; ld_wd = L5;
        tick();
        ld_valid = 1'b0;
        chk("stv_stall_k1", 64'(pipe_stall), 64'd0);
        for (int k = 2; k <= 8; k++) begin
            tick();
            chk($sformatf("stv_stall_k%0d", k), 64'(pipe_stall), 64'd0);
        end
        tick();
        chk("stv_stall_on", 64'(pipe_stall), 64'd1);
        chk("stv_pipe_wa", 64'(rf_wa), 64'd7);
        chk("stv_pipe_we", 64'(rf_we), 64'd1);
        chk("stv_ready", 64'(ld_ready), 64'd0);
        tick();
        chk("stv_stall_hold", 64'(pipe_stall), 64'd1);
        pipe_we = 1'b0;
        tick();
        chk("stv_grant_we", 64'(rf_we), 64'd1);
        chk("stv_grant_wa", 64'(rf_wa), 64'd5);
        chk("stv_grant_wd", 64'(rf_wd), 64'(L5));
        chk("stv_stall_off", 64'(pipe_stall), 64'd0);
        chk("stv_ready_back", 64'(ld_ready), 64'd1);

        // Same address while held
        pipe_we = 1'b1; pipe_wa = 4'd1; pipe_wd = P1;
        ld_valid = 1'b1; ld_wa = 4'd4; ld_wd = L4;
        tick();
        ld_valid = 1'b0;
        pipe_wa = 4'd4; pipe_wd = P4;
        chk("sa_no_drop_yet", 64'(ld_drop), 64'd0);
        tick();
        pipe_we = 1'b0;
        chk("sa_drop", 64'(ld_drop), 64'd1);
        chk("sa_wa", 64'(rf_wa), 64'd4);
        chk("sa_wd", 64'(rf_wd), 64'(P4));
        chk("sa_ready", 64'(ld_ready), 64'd1);
        tick();
        chk("sa_drop_pulse", 64'(ld_drop), 64'd0);
        chk("sa_no_ld_write", 64'(rf_we), 64'd0);
        tick();
        chk("sa_no_ld_write2", 64'(rf_we), 64'd0);

        // Same address in IDLE
        pipe_we = 1'b1; pipe_wa = 4'd9; pipe_wd = P9;
        ld_valid = 1'b1; ld_wa = 4'd9; ld_wd = L4;
        tick();
        pipe_we = 1'b0; ld_valid = 1'b0;
        chk("isa_wd", 64'(rf_wd), 64'(P9));
        chk("isa_drop", 64'(ld_drop), 64'd1);
        chk("isa_ready", 64'(ld_ready), 64'd1);
        tick();
        chk("isa_no_ld_write", 64'(rf_we), 64'd0);

        // Reset while in FORCE
        pipe_we = 1'b1; pipe_wa = 4'd7; pipe_wd = P7;
        ld_valid = 1'b1; ld_wa = 4'd8; ld_wd = L5;
        tick();
        ld_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("rf_force_stall", 64'(pipe_stall), 64'd1);
        rst = 1'b1;
        tick();
        chk("rf_rst_stall", 64'(pipe_stall), 64'd0);
        chk("rf_rst_ready", 64'(ld_ready), 64'd0);
        chk("rf_rst_we", 64'(rf_we), 64'd0);
        rst = 1'b0; pipe_we = 1'b0;
        tick();
        chk("rf_rel_ready", 64'(ld_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rf_no_ld_write%0d", k), 64'(rf_we), 64'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
